// File: rtl/pic_pkg.sv
// pic_pkg
//   Shared definitions for the 8259 INTA sequencer: FSM state encoding,
//   OCW2 command codes, reset priority and the rotating find-first helper.
package pic_pkg;

    localparam int         N_IRQ      = 8;
    localparam logic [2:0] RST_LOWEST = 3'd7;   // IR0 highest after reset

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } state_t;

    // OCW2 {R, SL, EOI}
    localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
    localparam logic [2:0] OCW2_S_EOI    = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
    localparam logic [2:0] OCW2_ROT_S    = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO = 3'b110;

    // Returns {found, idx}: the first set bit scanning upward from lowest+1,
    // i.e. the highest-ranked request under rotating priority.
    function automatic logic [3:0] rot_first(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        // Scan from the lowest rank down so the highest-ranked hit is written last.
        for (int k = 7; k >= 0; k--) begin
            idx = lowest + 3'd1 + 3'(k);
            if (vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // rank 0 is the highest priority
    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver
//   Combinational rotating find-first over an 8-bit vector.
//   i_vec    : candidate bits
//   i_lowest : current lowest-priority level
//   o_found  : any bit set
//   o_idx    : highest-ranked set bit (valid when o_found)
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [N_IRQ-1:0] i_vec,
    input  logic [2:0]       i_lowest,
    output logic             o_found,
    output logic [2:0]       o_idx
);

    logic [3:0] w_res;

    assign w_res   = rot_first(i_vec, i_lowest);
    assign o_found = w_res[3];
    assign o_idx   = w_res[2:0];

endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
//   8259 control core (single mode, 8086 vectors): IRR latch, priority
//   resolution against IMR/ISR, INT generation, two-pulse INTA FSM, ISR
//   set/clear via INTA, AEOI and OCW2 EOI commands, rotating priority.
//   Inputs : clk, rst (sync, high), irq, ltim, imr, aeoi, rot_aeoi, vec_base,
//            inta_n, eoi_vld, eoi_cmd, eoi_lvl
//   Outputs: int_out, vec_out, vec_oe, irr, isr, lowest_prio
module pic_inta_sequencer
    import pic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             ltim,
    input  logic [N_IRQ-1:0] imr,
    input  logic             aeoi,
    input  logic             rot_aeoi,
    input  logic [4:0]       vec_base,
    input  logic             inta_n,
    input  logic             eoi_vld,
    input  logic [2:0]       eoi_cmd,
    input  logic [2:0]       eoi_lvl,
    output logic             int_out,
    output logic [7:0]       vec_out,
    output logic             vec_oe,
    output logic [N_IRQ-1:0] irr,
    output logic [N_IRQ-1:0] isr,
    output logic [2:0]       lowest_prio
);

    state_t           r_state, w_state_nxt;
    logic [N_IRQ-1:0] r_irr, r_isr, r_irq_prev;
    logic [N_IRQ-1:0] w_irr_nxt, w_isr_nxt;
    logic [2:0]       r_low, w_low_nxt, r_lvl;
    logic             r_spur, r_inta_prev, r_int, w_int_nxt;
    logic [7:0]       r_vec;
    logic             r_vec_oe;

    logic             w_fall, w_rise, w_grant;
    logic             w_cand_found, w_ceil_found;
    logic [2:0]       w_cand_idx, w_ceil_idx;

    assign w_fall = ~inta_n &  r_inta_prev;
    assign w_rise =  inta_n & ~r_inta_prev;

    pic_priority_resolver u_cand (
        .i_vec    (r_irr & ~imr),
        .i_lowest (r_low),
        .o_found  (w_cand_found),
        .o_idx    (w_cand_idx)
    );

    pic_priority_resolver u_ceil (
        .i_vec    (r_isr),
        .i_lowest (r_low),
        .o_found  (w_ceil_found),
        .o_idx    (w_ceil_idx)
    );

    assign w_grant = (r_state == ST_IDLE) && w_fall && w_cand_found;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_fall) w_state_nxt = ST_ACK1;
            ST_ACK1: if (w_rise) w_state_nxt = ST_GAP;
            ST_GAP:  if (w_fall) w_state_nxt = ST_ACK2;
            ST_ACK2: if (w_rise) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_irr_nxt = ltim ? irq : (irq & (r_irr | ~r_irq_prev));
        // Grant clear beats a same-cycle edge on that bit.
        if (w_grant) w_irr_nxt[w_cand_idx] = 1'b0;
    end

    always_comb begin
        w_isr_nxt = r_isr;
        w_low_nxt = r_low;
        if (r_state == ST_ACK2 && w_rise && aeoi && !r_spur) begin
            w_isr_nxt[r_lvl] = 1'b0;
            if (rot_aeoi) w_low_nxt = r_lvl;
        end
        // EOI is evaluated after AEOI so its rotation wins; the ceiling is
        // taken from r_isr, i.e. before this cycle's INTA1 set.
        if (eoi_vld) begin
            case (eoi_cmd)
                OCW2_NS_EOI:   if (w_ceil_found) w_isr_nxt[w_ceil_idx] = 1'b0;
                OCW2_ROT_NS:   if (w_ceil_found) begin
                                   w_isr_nxt[w_ceil_idx] = 1'b0;
                                   w_low_nxt             = w_ceil_idx;
                               end
                OCW2_S_EOI:    w_isr_nxt[eoi_lvl] = 1'b0;
                OCW2_ROT_S:    begin
                                   w_isr_nxt[eoi_lvl] = 1'b0;
                                   w_low_nxt          = eoi_lvl;
                               end
                OCW2_SET_PRIO: w_low_nxt = eoi_lvl;
                default:       ;
            endcase
        end
        // INTA1 set beats an EOI clear of the same bit.
        if (w_grant) w_isr_nxt[w_cand_idx] = 1'b1;
    end

    // Looking at the next state keeps INT low from the INTA1 cycle on.
    assign w_int_nxt = (w_state_nxt == ST_IDLE) && w_cand_found &&
                       (!w_ceil_found || (rank(w_cand_idx, r_low) < rank(w_ceil_idx, r_low)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_irq_prev  <= '0;
            r_low       <= RST_LOWEST;
            r_lvl       <= 3'd7;
            r_spur      <= 1'b0;
            r_inta_prev <= 1'b1;
            r_int       <= 1'b0;
            r_vec       <= 8'h00;
            r_vec_oe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_irq_prev  <= irq;
            r_low       <= w_low_nxt;
            r_inta_prev <= inta_n;
            r_int       <= w_int_nxt;
            if (r_state == ST_IDLE && w_fall) begin
                r_lvl  <= w_cand_found ? w_cand_idx : 3'd7;
                r_spur <= ~w_cand_found;
            end
            if (r_state == ST_GAP && w_fall) begin
                r_vec    <= {vec_base, r_lvl};
                r_vec_oe <= 1'b1;
            end else if (r_state == ST_ACK2 && w_rise) begin
                r_vec_oe <= 1'b0;
            end
        end
    end

    assign int_out     = r_int;
    assign vec_out     = r_vec;
    assign vec_oe      = r_vec_oe;
    assign irr         = r_irr;
    assign isr         = r_isr;
    assign lowest_prio = r_low;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq, imr;
    logic       ltim, aeoi, rot_aeoi, inta_n, eoi_vld;
    logic [4:0] vec_base;
    logic [2:0] eoi_cmd, eoi_lvl;
    logic       int_out, vec_oe;
    logic [7:0] vec_out, irr, isr;
    logic [2:0] lowest_prio;

    int checks = 0;
    int errors = 0;

    pic_inta_sequencer dut (
        .clk(clk), .rst(rst), .irq(irq), .ltim(ltim), .imr(imr), .aeoi(aeoi),
        .rot_aeoi(rot_aeoi), .vec_base(vec_base), .inta_n(inta_n),
        .eoi_vld(eoi_vld), .eoi_cmd(eoi_cmd), .eoi_lvl(eoi_lvl),
        .int_out(int_out), .vec_out(vec_out), .vec_oe(vec_oe), .irr(irr),
        .isr(isr), .lowest_prio(lowest_prio)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoi_vld = 1'b1; eoi_cmd = cmd; eoi_lvl = lvl;
        tick();
        eoi_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = 8'h00; imr = 8'h00; ltim = 1'b0; aeoi = 1'b0;
        rot_aeoi = 1'b0; vec_base = 5'h08; inta_n = 1'b1; eoi_vld = 1'b0;
        eoi_cmd = 3'b000; eoi_lvl = 3'd0;
        tick(); tick();
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_int", {7'd0, int_out}, 8'h00);
        chk("rst_vec", vec_out, 8'h00);
        chk("rst_oe", {7'd0, vec_oe}, 8'h00);
        chk("rst_low", {5'd0, lowest_prio}, 8'h07);
        rst = 1'b0;
        tick();

        // 1: IR3, full INTA handshake
        irq = 8'h08; tick();
        chk("t1_irr", irr, 8'h08);
        chk("t1_int_lat", {7'd0, int_out}, 8'h00);
        tick();
        chk("t1_int", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0; tick();
        chk("t1_isr", isr, 8'h08);
        chk("t1_irr_clr", irr, 8'h00);
        chk("t1_int_ack1", {7'd0, int_out}, 8'h00);
        irq = 8'h00; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t1_vec", vec_out, 8'h43);
        chk("t1_oe", {7'd0, vec_oe}, 8'h01);
        inta_n = 1'b1; tick();
        chk("t1_oe_off", {7'd0, vec_oe}, 8'h00);
        chk("t1_isr_hold", isr, 8'h08);

        // 2: ISR ceiling blocks lower levels, higher passes, NS-EOI releases
        irq = 8'h20; tick(); tick();
        chk("t2_ir5_blocked", {7'd0, int_out}, 8'h00);
        irq = 8'h22; tick(); tick();
        chk("t2_ir1_int", {7'd0, int_out}, 8'h01);
        irq = 8'h20; tick(); tick();
        chk("t2_int_drop", {7'd0, int_out}, 8'h00);
        eoi(3'b001, 3'd0);
        chk("t2_nseoi", isr, 8'h00);
        tick();
        chk("t2_ir5_int", {7'd0, int_out}, 8'h01);
        imr = 8'h20; tick();
        chk("t2_imr", {7'd0, int_out}, 8'h00);
        imr = 8'h00; irq = 8'h00; tick(); tick();

        // 3: AEOI with rotation
        aeoi = 1'b1; rot_aeoi = 1'b1;
        irq = 8'h04; tick(); tick();
        inta_n = 1'b0; tick();
        chk("t3_isr", isr, 8'h04);
        irq = 8'h00; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        chk("t3_aeoi_isr", isr, 8'h00);
        chk("t3_low", {5'd0, lowest_prio}, 8'h02);
        irq = 8'h0C; tick(); tick();
        inta_n = 1'b0; tick();
        chk("t3_ir3_first", isr, 8'h08);
        chk("t3_irr", irr, 8'h04);
        irq = 8'h00; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t3_vec", vec_out, 8'h43);
        inta_n = 1'b1; tick();
        chk("t3_low2", {5'd0, lowest_prio}, 8'h03);
        aeoi = 1'b0; rot_aeoi = 1'b0;

        // 4: spurious
        irq = 8'h40; tick(); tick();
        chk("t4_int", {7'd0, int_out}, 8'h01);
        irq = 8'h00; tick();
        inta_n = 1'b0; tick();
        chk("t4_isr", isr, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t4_vec", vec_out, 8'h47);
        inta_n = 1'b1; tick();
        chk("t4_isr_end", isr, 8'h00);

        // 5: S-EOI colliding with INTA1 set, then set-priority
        irq = 8'h10; tick(); tick();
        inta_n = 1'b0;
        eoi(3'b011, 3'd4);
        chk("t5_set_wins", isr, 8'h10);
        irq = 8'h00; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t5_vec", vec_out, 8'h44);
        inta_n = 1'b1; tick();
        eoi(3'b011, 3'd4);
        chk("t5_seoi", isr, 8'h00);
        eoi(3'b110, 3'd0);
        chk("t5_setprio", {5'd0, lowest_prio}, 8'h00);
        irq = 8'h03; tick(); tick();
        inta_n = 1'b0; tick();
        chk("t5_ir1_first", isr, 8'h02);
        irq = 8'h00; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        eoi(3'b101, 3'd0);
        chk("t5_rotns_isr", isr, 8'h00);
        chk("t5_rotns_low", {5'd0, lowest_prio}, 8'h01);

        // 6: reset in GAP
        irq = 8'h01; tick(); tick();
        inta_n = 1'b0; tick();
        chk("t6_isr", isr, 8'h01);
        irq = 8'h00; inta_n = 1'b1; tick();
        rst = 1'b1; tick();
        chk("t6_oe", {7'd0, vec_oe}, 8'h00);
        chk("t6_isr_rst", isr, 8'h00);
        chk("t6_low", {5'd0, lowest_prio}, 8'h07);
        rst = 1'b0; tick();
        inta_n = 1'b0; tick();
        chk("t6_new_inta1", {7'd0, vec_oe}, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t6_vec", vec_out, 8'h47);
        chk("t6_oe2", {7'd0, vec_oe}, 8'h01);
        inta_n = 1'b1; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
